// File: rtl/speed_meas_multi.sv
// ============================================================================
// Module : speed_meas_multi
// Brief  : Multi-lane s1->s2 interval timer sharing one iterative speed divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module speed_meas_multi #(
  parameter int NUM_LANES   = 2,
  parameter int SYS_FREQ    = 50000000,
  parameter int WIDTH_MS    = 14,
  parameter int WIDTH_SPEED = 14,
  parameter int DIST_CONST  = 14400,
  parameter int SPEED_LIMIT = 60,
  localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_LANES-1:0]   i_s1,
  input  logic [NUM_LANES-1:0]   i_s2,
  input  logic [NUM_LANES-1:0]   i_open_req,
  input  logic [NUM_LANES-1:0]   i_close_req,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [LANE_W-1:0]      o_res_lane,
  output logic [WIDTH_SPEED-1:0] o_res_speed,
  output logic                   o_res_overspeed,
  output logic                   o_res_timeout,
  output logic [NUM_LANES-1:0]   o_barrier_en,
  output logic [NUM_LANES-1:0]   o_busy
);

  localparam int c_prescale = (SYS_FREQ / 1000 > 0) ? SYS_FREQ / 1000 : 1;
  localparam int c_pre_w    = (c_prescale > 1) ? $clog2(c_prescale) : 1;
  localparam int c_rem_w    = ((WIDTH_SPEED > WIDTH_MS) ? WIDTH_SPEED : WIDTH_MS) + 1;
  localparam int c_cnt_w    = (WIDTH_SPEED > 1) ? $clog2(WIDTH_SPEED) : 1;

  localparam logic [c_pre_w-1:0]     c_pre_last  = c_pre_w'(c_prescale - 1);
  localparam logic [c_pre_w-1:0]     c_pre_one   = c_pre_w'(1);
  localparam logic [WIDTH_MS-1:0]    c_ms_one    = WIDTH_MS'(1);
  localparam logic [WIDTH_MS-1:0]    c_ms_sat_m1 = {{(WIDTH_MS-1){1'b1}}, 1'b0};
  localparam logic [c_cnt_w-1:0]     c_cnt_last  = c_cnt_w'(WIDTH_SPEED - 1);
  localparam logic [c_cnt_w-1:0]     c_cnt_one   = c_cnt_w'(1);
  localparam logic [LANE_W-1:0]      c_lane_last = LANE_W'(NUM_LANES - 1);
  localparam logic [LANE_W-1:0]      c_lane_one  = LANE_W'(1);
  localparam logic [WIDTH_SPEED-1:0] c_dist      = WIDTH_SPEED'(DIST_CONST);
  localparam logic [WIDTH_SPEED-1:0] c_limit     = WIDTH_SPEED'(SPEED_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TIMING = 3'd1,
    ST_PEND   = 3'd2,
    ST_TOUT   = 3'd3,
    ST_WAIT   = 3'd4
  } lane_state_t;

  logic [NUM_LANES-1:0] w_req;
  logic [NUM_LANES-1:0] w_req_tout;
  logic [NUM_LANES-1:0] w_grant;
  logic [NUM_LANES-1:0] w_release;
  logic [WIDTH_MS-1:0]  w_lane_ms [NUM_LANES];
  logic                 w_hs;
  logic                 w_can_grant;
  logic                 w_gnt_any;
  logic [LANE_W-1:0]    w_gnt_idx;

  logic                   r_res_valid;
  logic [LANE_W-1:0]      r_res_lane;
  logic [WIDTH_SPEED-1:0] r_res_speed;
  logic                   r_res_overspeed;
  logic                   r_res_timeout;
  logic [NUM_LANES-1:0]   r_barrier;

  assign w_hs = r_res_valid & i_res_ready;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_state_t         r_state;
      lane_state_t         w_state_nxt;
      logic [c_pre_w-1:0]  r_pre;
      logic [WIDTH_MS-1:0] r_ms;
      logic                w_tick;

      assign w_tick         = (r_pre == c_pre_last);
      assign w_release[gi]  = w_hs && (r_res_lane == LANE_W'(gi));
      assign w_req[gi]      = (r_state == ST_PEND) || (r_state == ST_TOUT);
      assign w_req_tout[gi] = (r_state == ST_TOUT);
      assign w_lane_ms[gi]  = r_ms;
      assign o_busy[gi]     = (r_state != ST_IDLE);

      // s1 outranks s2; s2 outranks the saturating tick
      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          ST_IDLE:   if (i_s1[gi]) w_state_nxt = ST_TIMING;
          ST_TIMING: begin
            if (i_s1[gi])                       w_state_nxt = ST_TIMING;
            else if (i_s2[gi])                  w_state_nxt = ST_PEND;
            else if (w_tick && r_ms == c_ms_sat_m1) w_state_nxt = ST_TOUT;
          end
          ST_PEND,
          ST_TOUT:   if (w_grant[gi]) w_state_nxt = ST_WAIT;
          ST_WAIT:   if (w_release[gi]) w_state_nxt = ST_IDLE;
          default:   w_state_nxt = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= ST_IDLE;
          r_pre   <= '0;
          r_ms    <= '0;
        end else begin
          r_state <= w_state_nxt;
          if (i_s1[gi] && (r_state == ST_IDLE || r_state == ST_TIMING)) begin
            r_pre <= '0;
            r_ms  <= '0;
          end else if (r_state == ST_TIMING && !i_s2[gi]) begin
            if (w_tick) begin
              r_pre <= '0;
              r_ms  <= r_ms + c_ms_one;
            end else begin
              r_pre <= r_pre + c_pre_one;
            end
          end
        end
      end
    end
  endgenerate

  logic                   r_div_busy;
  logic                   r_div_fin;
  logic                   r_tout_sel;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_rem_w-1:0]     r_rem;
  logic [WIDTH_SPEED-1:0] r_quo;
  logic [WIDTH_MS-1:0]    r_dvs;
  logic [LANE_W-1:0]      r_lane;
  logic [LANE_W-1:0]      r_rr;

  logic [c_rem_w-1:0]     w_trial;
  logic [c_rem_w-1:0]     w_dvs_ext;
  logic                   w_fit;
  logic [WIDTH_SPEED-1:0] w_speed_fin;

  // The divider slot frees on the handshake edge, so a waiting lane is granted on that same edge
  assign w_can_grant = !r_div_busy && !r_div_fin && (!r_res_valid || i_res_ready);

  function automatic int f_wrap(input int a);
    return (a >= NUM_LANES) ? a - NUM_LANES : a;
  endfunction

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (w_can_grant) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (!w_gnt_any && w_req[f_wrap(int'(r_rr) + k)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = LANE_W'(f_wrap(int'(r_rr) + k));
        end
      end
    end
    w_grant = w_gnt_any ? (NUM_LANES'(1) << w_gnt_idx) : '0;
  end

  assign w_trial     = {r_rem[c_rem_w-2:0], r_quo[WIDTH_SPEED-1]};
  assign w_dvs_ext   = {{(c_rem_w-WIDTH_MS){1'b0}}, r_dvs};
  assign w_fit       = (w_trial >= w_dvs_ext);
  assign w_speed_fin = r_tout_sel ? '0 : ((r_dvs == '0) ? '1 : r_quo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_busy      <= 1'b0;
      r_div_fin       <= 1'b0;
      r_tout_sel      <= 1'b0;
      r_cnt           <= '0;
      r_rem           <= '0;
      r_quo           <= '0;
      r_dvs           <= '0;
      r_lane          <= '0;
      r_rr            <= '0;
      r_res_valid     <= 1'b0;
      r_res_lane      <= '0;
      r_res_speed     <= '0;
      r_res_overspeed <= 1'b0;
      r_res_timeout   <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_lane     <= w_gnt_idx;
        r_rr       <= (w_gnt_idx == c_lane_last) ? '0 : w_gnt_idx + c_lane_one;
        r_tout_sel <= w_req_tout[w_gnt_idx];
        r_dvs      <= w_lane_ms[w_gnt_idx];
        r_rem      <= '0;
        r_quo      <= c_dist;
        r_cnt      <= '0;
        if (w_req_tout[w_gnt_idx]) r_div_fin  <= 1'b1;
        else                       r_div_busy <= 1'b1;
      end else if (r_div_busy) begin
        // Restoring step: dividend shifts out of r_quo as quotient bits shift in
        r_rem <= w_fit ? (w_trial - w_dvs_ext) : w_trial;
        r_quo <= {r_quo[WIDTH_SPEED-2:0], w_fit};
        r_cnt <= r_cnt + c_cnt_one;
        if (r_cnt == c_cnt_last) begin
          r_div_busy <= 1'b0;
          r_div_fin  <= 1'b1;
        end
      end

      if (r_div_fin) begin
        r_div_fin       <= 1'b0;
        r_res_valid     <= 1'b1;
        r_res_lane      <= r_lane;
        r_res_speed     <= w_speed_fin;
        r_res_overspeed <= (w_speed_fin > c_limit);
        r_res_timeout   <= r_tout_sel;
      end else if (w_hs) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_barrier <= '0;
    else          r_barrier <= (r_barrier & ~i_close_req) | i_open_req;
  end

  assign o_res_valid     = r_res_valid;
  assign o_res_lane      = r_res_lane;
  assign o_res_speed     = r_res_speed;
  assign o_res_overspeed = r_res_overspeed;
  assign o_res_timeout   = r_res_timeout;
  assign o_barrier_en    = r_barrier;

endmodule

`default_nettype wire

// File: tb/tb_speed_meas_multi.sv
// ============================================================================
// Module : tb_speed_meas_multi
// Brief  : Directed self-checking bench for speed_meas_multi (2 lanes, 2 clk/ms).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_speed_meas_multi;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s1, s2, open_req, close_req;
  logic        res_ready;
  logic        res_valid;
  logic [0:0]  res_lane;
  logic [13:0] res_speed;
  logic        res_overspeed, res_timeout;
  logic [1:0]  barrier_en, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  speed_meas_multi #(
    .NUM_LANES(2), .SYS_FREQ(2000), .WIDTH_MS(14), .WIDTH_SPEED(14),
    .DIST_CONST(14400), .SPEED_LIMIT(60)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_s1(s1), .i_s2(s2), .i_open_req(open_req), .i_close_req(close_req),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_lane(res_lane),
    .o_res_speed(res_speed), .o_res_overspeed(res_overspeed), .o_res_timeout(res_timeout),
    .o_barrier_en(barrier_en), .o_busy(busy)
  );

  task automatic pulse(input logic [1:0] a, input logic [1:0] b);
    s1 = a; s2 = b;
    @(negedge clk);
    s1 = 2'b00; s2 = 2'b00;
  endtask

  task automatic timed(input logic [1:0] m, input int ms);
    pulse(m, 2'b00);
    repeat (ms * P) @(negedge clk);
    pulse(2'b00, m);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s1 = 0; s2 = 0; open_req = 0; close_req = 0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s1 = 0; s2 = 0; open_req = 0; close_req = 0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b expected 00", busy); end
    checks++; if (barrier_en !== 2'b00) begin errors++; $display("FAIL rst_barrier: got %b expected 00", barrier_en); end
    checks++; if ({res_lane, res_speed, res_overspeed, res_timeout} !== 17'd0) begin
      errors++; $display("FAIL rst_res: got lane=%0d speed=%0d os=%b to=%b expected all 0", res_lane, res_speed, res_overspeed, res_timeout);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lane0_speed();
    int cyc;
    res_ready = 1'b1;
    timed(2'b01, 240);
    wait_valid(40, cyc);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL l0_valid: got %b expected 1", res_valid); end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL l0_latency: got %0d expected 16", cyc); end
    checks++; if (res_lane !== 1'b0) begin errors++; $display("FAIL l0_lane: got %0d expected 0", res_lane); end
    checks++; if (res_speed !== 14'd60) begin errors++; $display("FAIL l0_speed: got %0d expected 60", res_speed); end
    checks++; if ({res_overspeed, res_timeout} !== 2'b00) begin errors++; $display("FAIL l0_flags: got %b expected 00", {res_overspeed, res_timeout}); end
    @(negedge clk);
    checks++; if ({res_valid, busy} !== 3'b000) begin errors++; $display("FAIL l0_release: got valid/busy %b expected 000", {res_valid, busy}); end
  endtask

  task automatic test_hold();
    int cyc;
    res_ready = 1'b0;
    timed(2'b10, 120);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane, res_speed, res_overspeed, res_timeout} !== {1'b1, 1'b1, 14'd120, 1'b1, 1'b0}) begin
      errors++; $display("FAIL l1_result: got v=%b lane=%0d speed=%0d os=%b to=%b expected v=1 lane=1 speed=120 os=1 to=0",
                         res_valid, res_lane, res_speed, res_overspeed, res_timeout);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, res_lane, res_speed, res_overspeed, res_timeout, busy} !== {1'b1, 1'b1, 14'd120, 1'b1, 1'b0, 2'b10}) begin
        errors++; $display("FAIL l1_hold cycle %0d: got v=%b lane=%0d speed=%0d busy=%b expected v=1 lane=1 speed=120 busy=10",
                           i, res_valid, res_lane, res_speed, busy);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if ({res_valid, busy} !== 3'b000) begin errors++; $display("FAIL l1_release: got valid/busy %b expected 000", {res_valid, busy}); end
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    // first tie after reset: lane0 then lane1, second granted on the handshake edge
    pulse(2'b11, 2'b00); repeat (10 * P) @(negedge clk); pulse(2'b00, 2'b11);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane, res_speed} !== {1'b1, 1'b0, 14'd1440}) begin
      errors++; $display("FAIL tie1_first: got v=%b lane=%0d speed=%0d expected v=1 lane=0 speed=1440", res_valid, res_lane, res_speed);
    end
    @(negedge clk);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane, res_speed} !== {1'b1, 1'b1, 14'd1440}) begin
      errors++; $display("FAIL tie1_second: got v=%b lane=%0d speed=%0d expected v=1 lane=1 speed=1440", res_valid, res_lane, res_speed);
    end
    checks++; if (cyc !== 15) begin errors++; $display("FAIL tie1_b2b_latency: got %0d expected 15", cyc); end
    @(negedge clk);
    timed(2'b01, 10);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane} !== 2'b10) begin errors++; $display("FAIL solo_lane0: got v/lane %b expected 10", {res_valid, res_lane}); end
    @(negedge clk);
    // pointer now sits on lane1
    pulse(2'b11, 2'b00); repeat (10 * P) @(negedge clk); pulse(2'b00, 2'b11);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane} !== 2'b11) begin errors++; $display("FAIL tie2_first: got v/lane %b expected 11", {res_valid, res_lane}); end
    @(negedge clk);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_lane} !== 2'b10) begin errors++; $display("FAIL tie2_second: got v/lane %b expected 10", {res_valid, res_lane}); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    res_ready = 1'b1;
    pulse(2'b01, 2'b00);
    wait_valid(33000, cyc);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL tout_valid: got %b expected 1", res_valid); end
    checks++; if (cyc !== 32768) begin errors++; $display("FAIL tout_latency: got %0d expected 32768", cyc); end
    checks++; if ({res_lane, res_speed, res_overspeed, res_timeout} !== {1'b0, 14'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL tout_result: got lane=%0d speed=%0d os=%b to=%b expected lane=0 speed=0 os=0 to=1",
                         res_lane, res_speed, res_overspeed, res_timeout);
    end
    @(negedge clk);
    checks++; if ({res_valid, busy} !== 3'b000) begin errors++; $display("FAIL tout_release: got valid/busy %b expected 000", {res_valid, busy}); end
  endtask

  task automatic test_zero_and_same();
    int cyc;
    bit seen;
    res_ready = 1'b1;
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_speed, res_overspeed, res_timeout} !== {1'b1, 14'd16383, 1'b1, 1'b0}) begin
      errors++; $display("FAIL zero_ms: got v=%b speed=%0d os=%b to=%b expected v=1 speed=16383 os=1 to=0",
                         res_valid, res_speed, res_overspeed, res_timeout);
    end
    @(negedge clk);
    pulse(2'b00, 2'b10);
    checks++; if (busy !== 2'b00) begin errors++; $display("FAIL s2_idle: got busy %b expected 00", busy); end
    pulse(2'b01, 2'b01);
    checks++; if (busy !== 2'b01) begin errors++; $display("FAIL s1s2_same: got busy %b expected 01", busy); end
    seen = 1'b0;
    repeat (40) begin
      if (res_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL s1s2_no_result: got valid seen %b expected 0", seen); end
    pulse(2'b00, 2'b01);
    wait_valid(40, cyc);
    checks++; if ({res_valid, res_speed} !== {1'b1, 14'd720}) begin
      errors++; $display("FAIL s1s2_timing: got v=%b speed=%0d expected v=1 speed=720", res_valid, res_speed);
    end
    @(negedge clk);
  endtask

  task automatic test_barrier();
    open_req = 2'b01; @(negedge clk); open_req = 2'b00;
    checks++; if (barrier_en !== 2'b01) begin errors++; $display("FAIL bar_open: got %b expected 01", barrier_en); end
    open_req = 2'b11; close_req = 2'b01; @(negedge clk); open_req = 2'b00; close_req = 2'b00;
    checks++; if (barrier_en !== 2'b11) begin errors++; $display("FAIL bar_open_wins: got %b expected 11", barrier_en); end
    close_req = 2'b10; @(negedge clk); close_req = 2'b00;
    checks++; if (barrier_en !== 2'b01) begin errors++; $display("FAIL bar_close: got %b expected 01", barrier_en); end
  endtask

  task automatic test_reset_mid_divide();
    bit seen;
    res_ready = 1'b1;
    timed(2'b01, 5);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if ({res_valid, busy, barrier_en} !== 5'b00000) begin
      errors++; $display("FAIL rst_mid: got valid/busy/bar %b expected 00000", {res_valid, busy, barrier_en});
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy !== 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got activity %b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_lane0_speed();
    test_hold();
    test_round_robin();
    test_timeout();
    test_zero_and_same();
    test_barrier();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
